// File: rtl/conv_window_gen.sv
// Sliding K x K window generator over a raster-scanned pixel stream.
// A (K-1) lines + K pixels delay line feeds a registered window with valid/ready handshake.
module conv_window_gen #(
    parameter int DATA_W    = 18,
    parameter int K         = 7,
    parameter int LINE_LEN  = 70,
    parameter int NUM_LINES = 186,
    parameter int STRIDE    = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] in_pixel,
    output logic                     in_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [K*K*DATA_W-1:0]    win,
    output logic                     frame_done
);

    localparam int D  = (K - 1) * LINE_LEN + K;
    localparam int FW = $clog2(LINE_LEN + 1);
    localparam int SW = $clog2(NUM_LINES + 1);
    localparam int WW = K * K * DATA_W;

    localparam logic [FW-1:0] F_ONE  = FW'(1);
    localparam logic [FW-1:0] F_K    = FW'(K);
    localparam logic [FW-1:0] F_LAST = FW'(LINE_LEN);
    localparam logic [SW-1:0] S_ONE  = SW'(1);
    localparam logic [SW-1:0] S_K    = SW'(K);
    localparam logic [SW-1:0] S_LAST = SW'(NUM_LINES);
    localparam logic [1:0]    PH_LAST = 2'(STRIDE - 1);

    logic [DATA_W-1:0] line_q [D];
    logic [DATA_W-1:0] tap    [D];

    logic [FW-1:0] f_q, f_d;
    logic [SW-1:0] s_q, s_d;
    logic [1:0]    f_ph_q, f_ph_d;
    logic [1:0]    s_ph_q, s_ph_d;
    logic          out_valid_q, out_valid_d;
    logic [WW-1:0] win_q, win_d;
    logic          frame_done_q, frame_done_d;

    logic accept, shift_en, is_center, last_f, last_s;

    function automatic logic [1:0] ph_next(input logic [1:0] ph);
        return (ph == PH_LAST) ? 2'd0 : ph + 2'd1;
    endfunction

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    // clr and reset both win over an offered pixel, so it never reaches the line.
    assign shift_en = accept && rst && !clr;

    assign last_f    = (f_q == F_LAST);
    assign last_s    = (s_q == S_LAST);
    // Phase counters hold (pos-K) mod STRIDE once pos reaches K, and stay 0 before.
    assign is_center = (s_q >= S_K) && (f_q >= F_K) && (s_ph_q == 2'd0) && (f_ph_q == 2'd0);

    // Post-shift view of the delay line: what it will hold after this accept.
    always_comb begin
        for (int i = 0; i < D - 1; i++) begin
            tap[i] = line_q[i + 1];
        end
        tap[D-1] = in_pixel;
    end

    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        f_d          = f_q;
        s_d          = s_q;
        f_ph_d       = f_ph_q;
        s_ph_d       = s_ph_q;
        out_valid_d  = out_valid_q;
        win_d        = win_q;
        frame_done_d = 1'b0;

        if (shift_en) begin
            frame_done_d = last_f && last_s;
            if (last_f) begin
                f_d    = F_ONE;
                f_ph_d = 2'd0;
                if (last_s) begin
                    s_d    = S_ONE;
                    s_ph_d = 2'd0;
                end else begin
                    s_d    = s_q + S_ONE;
                    s_ph_d = (s_q >= S_K) ? ph_next(s_ph_q) : 2'd0;
                end
            end else begin
                f_d    = f_q + F_ONE;
                f_ph_d = (f_q >= F_K) ? ph_next(f_ph_q) : 2'd0;
            end
        end

        if (shift_en && is_center) begin
            out_valid_d = 1'b1;
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    win_d[(r*K + c)*DATA_W +: DATA_W] = tap[r*LINE_LEN + c];
                end
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            f_q          <= F_ONE;
            s_q          <= S_ONE;
            f_ph_q       <= 2'd0;
            s_ph_q       <= 2'd0;
            out_valid_q  <= 1'b0;
            win_q        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            f_q          <= f_d;
            s_q          <= s_d;
            f_ph_q       <= f_ph_d;
            s_ph_q       <= s_ph_d;
            out_valid_q  <= out_valid_d;
            win_q        <= win_d;
            frame_done_q <= frame_done_d;
        end
    end

    // NOTE: the delay line has no reset; windows only ever read pixels of the current frame.
    always_ff @(posedge clk) begin
        if (shift_en) begin
            line_q <= tap;
        end
    end

    assign out_valid  = out_valid_q;
    assign win        = win_q;
    assign frame_done = frame_done_q;

endmodule
